// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them to
// instruction memory at word addresses 0,1,2,... Optional XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_num_words,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_word_count,
  output logic [31:0]       o_checksum
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        idx_q;
  logic [31:0]       word_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   target_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       wdata_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W:0]   target_d;
  logic [ADDR_W:0]   count_d;
  logic [31:0]       word_d;
  logic              byte_acc_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  function automatic logic [31:0] xor_accumulate(input logic [31:0] acc, input logic [31:0] word);
    return acc ^ word;
  endfunction
`endif

  // Clamped word target, next count and the word with the incoming byte merged in.
  always_comb begin
    target_d   = i_num_words;
    count_d    = count_q + CNT_ONE;
    word_d     = word_q;
    byte_acc_s = i_byte_valid & ready_q;
    if (i_num_words > MAX_WORDS) begin
      target_d = MAX_WORDS;
    end else begin
      target_d = i_num_words;
    end
    case (idx_q)
      2'd0:    word_d[31:24] = i_byte;
      2'd1:    word_d[23:16] = i_byte;
      2'd2:    word_d[15:8]  = i_byte;
      2'd3:    word_d[7:0]   = i_byte;
      default: word_d        = word_q;
    endcase
  end

  // Loader FSM with all outputs held in registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_ZERO;
      idx_q      <= 2'd0;
      word_q     <= 32'h0;
      count_q    <= CNT_ZERO;
      target_q   <= CNT_ZERO;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_q <= ADDR_ZERO;
      wdata_q    <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum_q <= 32'h0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            target_q <= target_d;
            addr_q   <= ADDR_ZERO;
            idx_q    <= 2'd0;
            count_q  <= CNT_ZERO;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_q <= 32'h0;
`endif
            if (target_d == CNT_ZERO) begin
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (byte_acc_s) begin
            word_q <= word_d;
            idx_q  <= idx_q + 2'd1;
            // The fourth byte completes the word; issue the write straight from word_d.
            if (idx_q == 2'd3) begin
              state_q    <= ST_WRITE;
              ready_q    <= 1'b0;
              we_q       <= 1'b1;
              mem_addr_q <= addr_q;
              wdata_q    <= word_d;
            end
          end
        end
        ST_WRITE: begin
          addr_q  <= addr_q + ADDR_ONE;
          count_q <= count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum_q <= xor_accumulate(checksum_q, wdata_q);
`endif
          if (count_d == target_q) begin
            state_q <= ST_DONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_LOAD;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready = ready_q;
  assign o_mem_we     = we_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_word_count = count_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign o_checksum = checksum_q;
`else
  assign o_checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench with a transaction-level model (expected write queue,
// word count and checksum per load). Instance a uses ADDR_W=8, instance b uses ADDR_W=2.
`timescale 1ns/1ps
module tb_imem_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, bv;
  logic [7:0]  bd;
  logic [8:0]  nw_a;
  logic [2:0]  nw_b;
  logic        rdy_a, we_a, busy_a, done_a;
  logic [7:0]  addr_a;
  logic [31:0] wd_a, ck_a;
  logic [8:0]  cnt_a;
  logic        rdy_b, we_b, busy_b, done_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b, ck_b;
  logic [2:0]  cnt_b;

  imem_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .reset(rst_n), .i_start(start_a), .i_num_words(nw_a),
    .i_byte_valid(bv), .i_byte(bd), .o_byte_ready(rdy_a), .o_mem_we(we_a),
    .o_mem_addr(addr_a), .o_mem_wdata(wd_a), .o_busy(busy_a), .o_done(done_a),
    .o_word_count(cnt_a), .o_checksum(ck_a)
  );

  imem_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(rst_n), .i_start(start_b), .i_num_words(nw_b),
    .i_byte_valid(bv), .i_byte(bd), .o_byte_ready(rdy_b), .o_mem_we(we_b),
    .o_mem_addr(addr_b), .o_mem_wdata(wd_b), .o_busy(busy_b), .o_done(done_b),
    .o_word_count(cnt_b), .o_checksum(ck_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  logic [7:0]  prog [0:15];
  int          exq_addr_a[$], exq_addr_b[$];
  logic [31:0] exq_data_a[$], exq_data_b[$];
  int          exp_cnt_a, exp_cnt_b;
  logic [31:0] exp_ck_a, exp_ck_b;
  int          we_cyc_a[$];
  int          last_we_a = 0;
  logic        prev_we_a = 1'b0, prev_we_b = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h, required no such event", name, act);
  endtask

  // Compare process: every write must match the model queue; spec invariants each cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (we_a) begin
        if (exq_data_a.size() == 0) bad("a_extra_write", wd_a);
        else begin
          chk("a_addr", 32'(addr_a), 32'(exq_addr_a.pop_front()));
          chk("a_wdata", wd_a, exq_data_a.pop_front());
        end
        we_cyc_a.push_back(cycle);
        last_we_a <= cycle;
      end
      if (we_b) begin
        if (exq_data_b.size() == 0) bad("b_extra_write", wd_b);
        else begin
          chk("b_addr", 32'(addr_b), 32'(exq_addr_b.pop_front()));
          chk("b_wdata", wd_b, exq_data_b.pop_front());
        end
      end
      chk("a_we_single", 32'(we_a & prev_we_a), 32'h0);
      chk("b_we_single", 32'(we_b & prev_we_b), 32'h0);
      chk("a_busy", 32'(busy_a), 32'(rdy_a | we_a));
      chk("b_busy", 32'(busy_b), 32'(rdy_b | we_b));
      chk("a_done_busy", 32'(done_a & busy_a), 32'h0);
      chk("b_done_busy", 32'(done_b & busy_b), 32'h0);
      prev_we_a <= we_a;
      prev_we_b <= we_b;
    end else begin
      prev_we_a <= 1'b0;
      prev_we_b <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model a load: clamp the count, queue expected words, then pulse start.
  task automatic start_load(input bit sel, input int n, input int base);
    int depth, m;
    logic [31:0] w, ck;
    depth = sel ? 4 : 256;
    m = (n > depth) ? depth : n;
    ck = 32'h0;
    for (int k = 0; k < m; k++) begin
      w = {prog[base+4*k], prog[base+4*k+1], prog[base+4*k+2], prog[base+4*k+3]};
      ck ^= w;
      if (sel) begin exq_addr_b.push_back(k); exq_data_b.push_back(w); end
      else     begin exq_addr_a.push_back(k); exq_data_a.push_back(w); end
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    ck = 32'h0;
`endif
    if (sel) begin exp_cnt_b = m; exp_ck_b = ck; nw_b = 3'(n); start_b = 1'b1; end
    else     begin exp_cnt_a = m; exp_ck_a = ck; nw_a = 9'(n); start_a = 1'b1; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    chk(sel ? "b_start_ready" : "a_start_ready", 32'(sel ? rdy_b : rdy_a), 32'(m != 0));
    chk(sel ? "b_start_done" : "a_start_done", 32'(sel ? done_b : done_a), 32'(m == 0));
    chk(sel ? "b_start_count" : "a_start_count", sel ? 32'(cnt_b) : 32'(cnt_a), 32'h0);
  endtask

  task automatic push_byte(input bit sel, input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      int g;
      g = $urandom_range(3, 0);
      bv = 1'b0;
      for (int i = 0; i < g; i++) begin
        if ($urandom_range(1, 0) == 1) begin nw_a = 9'd0; start_a = 1'b1; end
        tick();
        start_a = 1'b0;
      end
    end
    bv = 1'b1;
    bd = b;
    t = 0;
    while (1) begin
      @(negedge clk);
      if ((sel ? rdy_b : rdy_a) === 1'b1) break;
      t++;
      if (t > 200) begin bad("byte_timeout", 32'(b)); break; end
    end
    tick();
    bv = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int c);
    int t;
    t = 0;
    c = -1;
    while (t <= 100) begin
      @(negedge clk);
      if ((sel ? done_b : done_a) === 1'b1) begin c = cycle; break; end
      t++;
    end
    if (c < 0) bad(sel ? "b_done_timeout" : "a_done_timeout", 32'(t));
    tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(rdy_a | rdy_b), 32'h0);
    chk({tag, "_we"}, 32'(we_a | we_b), 32'h0);
    chk({tag, "_busy"}, 32'(busy_a | busy_b), 32'h0);
    chk({tag, "_done"}, 32'(done_a | done_b), 32'h0);
    chk({tag, "_addr"}, 32'(addr_a) | 32'(addr_b), 32'h0);
    chk({tag, "_wdata"}, wd_a | wd_b, 32'h0);
    chk({tag, "_count"}, 32'(cnt_a) | 32'(cnt_b), 32'h0);
    chk({tag, "_cksum"}, ck_a | ck_b, 32'h0);
  endtask

  initial begin
    int c;
    logic [31:0] ck_lit;
    prog[0]  = 8'h20; prog[1]  = 8'h08; prog[2]  = 8'h00; prog[3]  = 8'h05;
    prog[4]  = 8'h00; prog[5]  = 8'h85; prog[6]  = 8'h50; prog[7]  = 8'h20;
    prog[8]  = 8'hDE; prog[9]  = 8'hAD; prog[10] = 8'hBE; prog[11] = 8'hEF;
    prog[12] = 8'h01; prog[13] = 8'h23; prog[14] = 8'h45; prog[15] = 8'h67;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck_lit = 32'h208D5025;
`else
    ck_lit = 32'h0;
`endif

    // Reset held with bytes driven, then idle after release.
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; nw_a = 9'd0; nw_b = 3'd0;
    bv = 1'b1; bd = 8'hA5;
    repeat (3) tick();
    chk_reset_state("rst");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_ready", 32'(rdy_a | rdy_b), 32'h0);
    chk("idle_busy", 32'(busy_a | busy_b), 32'h0);
    chk("idle_done", 32'(done_a | done_b), 32'h0);
    bv = 1'b0;

    // Two words at full rate.
    we_cyc_a.delete();
    start_load(1'b0, 2, 0);
    chk("model_w0", exq_data_a[0], 32'h20080005);
    chk("model_w1", exq_data_a[1], 32'h00855020);
    for (int i = 0; i < 8; i++) push_byte(1'b0, prog[i], 1'b0);
    wait_done(1'b0, c);
    chk("a_done_after_write", 32'(c), 32'(last_we_a + 1));
    chk("a_we_pulses", 32'(we_cyc_a.size()), 32'd2);
    if (we_cyc_a.size() == 2) chk("a_we_spacing", 32'(we_cyc_a[1] - we_cyc_a[0]), 32'd5);
    chk("a_count2", 32'(cnt_a), 32'd2);
    chk("a_cksum2", ck_a, ck_lit);
    chk("a_last_addr", 32'(addr_a), 32'd1);
    chk("a_last_wdata", wd_a, 32'h00855020);
    chk("a_queue2", 32'(exq_data_a.size()), 32'd0);

    // Zero-word load from DONE.
    start_load(1'b0, 0, 0);
    chk("a_zero_cksum", ck_a, 32'h0);
    repeat (3) tick();
    chk("a_zero_done", 32'(done_a), 32'd1);
    chk("a_zero_count", 32'(cnt_a), 32'd0);
    chk("a_zero_queue", 32'(exq_data_a.size()), 32'd0);

    // Same program with random valid gaps and stray start pulses.
    start_load(1'b0, 2, 0);
    for (int i = 0; i < 8; i++) push_byte(1'b0, prog[i], 1'b1);
    wait_done(1'b0, c);
    chk("a_gap_count", 32'(cnt_a), 32'(exp_cnt_a));
    chk("a_gap_cksum", ck_a, exp_ck_a);
    chk("a_gap_queue", 32'(exq_data_a.size()), 32'd0);

    // Reset after two bytes of word 1: partial word never written, restart at 0.
    start_load(1'b0, 3, 0);
    for (int i = 0; i < 6; i++) push_byte(1'b0, prog[i], 1'b0);
    repeat (3) tick();
    chk("a_pending_words", 32'(exq_data_a.size()), 32'd2);
    rst_n = 1'b0;
    repeat (2) tick();
    chk_reset_state("midrst");
    exq_addr_a.delete();
    exq_data_a.delete();
    rst_n = 1'b1;
    tick();
    start_load(1'b0, 1, 4);
    for (int i = 4; i < 8; i++) push_byte(1'b0, prog[i], 1'b0);
    wait_done(1'b0, c);
    chk("a_restart_count", 32'(cnt_a), 32'd1);
    chk("a_restart_addr", 32'(addr_a), 32'd0);
    chk("a_restart_cksum", ck_a, exp_ck_a);
    chk("a_restart_queue", 32'(exq_data_a.size()), 32'd0);

    // ADDR_W=2 instance: 5 words requested clamps to 4.
    start_load(1'b1, 5, 0);
    for (int i = 0; i < 16; i++) push_byte(1'b1, prog[i], 1'b0);
    wait_done(1'b1, c);
    chk("b_count", 32'(cnt_b), 32'd4);
    chk("b_count_model", 32'(cnt_b), 32'(exp_cnt_b));
    chk("b_cksum", ck_b, exp_ck_b);
    chk("b_queue", 32'(exq_data_b.size()), 32'd0);
    chk("b_last_addr", 32'(addr_b), 32'd3);
    bv = 1'b1;
    bd = 8'hFF;
    repeat (3) tick();
    chk("b_done_noready", 32'(rdy_b), 32'h0);
    chk("b_done_hold", 32'(done_b), 32'd1);
    chk("b_done_count", 32'(cnt_b), 32'd4);
    bv = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the fetch stage: streams a program into the instruction memory that the fetch path later reads. Accepts bytes over a valid/ready handshake and packs them big-endian into 32-bit words. Issues one single-cycle write per word at sequential word addresses starting at 0, then reports completion. This lets a bench or boot path fill the memory through its write port instead of loading it directly.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; memory depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  : single clock, rising edge.
- `reset`  in  1  : asynchronous, active-low reset (asserted when 0).
- `i_start`  in  1  : begin a load; honoured only in IDLE or DONE.
- `i_num_words`  in  ADDR_W+1  : words to load; sampled on an accepted start.
- `i_byte_valid`  in  1  : `i_byte` holds a byte.
- `i_byte`  in  8  : program byte, most-significant byte of each word first.
- `o_byte_ready`  out  1  : loader can accept a byte this cycle.
- `o_mem_we`  out  1  : instruction-memory write strobe, one cycle per word.
- `o_mem_addr`  out  ADDR_W  : word address of the write.
- `o_mem_wdata`  out  32  : assembled word.
- `o_busy`  out  1  : high in LOAD or WRITE.
- `o_done`  out  1  : high in DONE.
- `o_word_count`  out  ADDR_W+1  : words written since the last start.
- `o_checksum`  out  32  : XOR of all words written (see Configuration).

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE, or DONE, with `i_start`=1:
  - sample `i_num_words`; values above 2^ADDR_W clamp to 2^ADDR_W;
  - clear the address, byte index, word count and checksum;
  - go to LOAD, or to DONE directly when the clamped count is 0.
- `i_start` in LOAD or WRITE is ignored.
- LOAD: `o_byte_ready`=1. A byte is accepted on a rising edge with `i_byte_valid`&`o_byte_ready`.
  - Byte index 0..3 maps to bits [31:24], [23:16], [15:8], [7:0].
  - The index wraps 3→0.
  - Accepting byte 3 moves the state to WRITE.
- WRITE (exactly one cycle): `o_byte_ready`=0.
  - `o_mem_we`=1, with `o_mem_addr` = current address and `o_mem_wdata` = assembled word.
  - On exit: address+1 (wraps modulo 2^ADDR_W), word count+1, checksum ^= word.
  - Next state is DONE if the new count equals the sampled count, else LOAD.
- DONE: held until a new `i_start` or reset. Bytes are not accepted.
- `o_mem_we`=0 in every state except WRITE. The address and data outputs hold their last values otherwise.
- Reset mid-operation aborts immediately; the partial word is discarded and never written.

## Timing
- Reset values:
  - state IDLE;
  - `o_byte_ready`, `o_mem_we`, `o_busy`, `o_done` = 0;
  - `o_mem_addr`, `o_mem_wdata`, `o_word_count`, `o_checksum` = 0.
- Start accepted on edge T: LOAD, with `o_byte_ready`=1, from cycle T+1.
- Fourth byte accepted on edge N: `o_mem_we`=1 during cycle N+1. The next byte can be accepted no earlier than edge N+2.
- Peak rate is 5 cycles per word. Gaps in `i_byte_valid` stall the loader without losing state.
- `o_done` rises in the cycle after the last WRITE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: `o_checksum` accumulates the XOR of every written word and is cleared on an accepted start.
- Not defined: the checksum register is not built and `o_checksum` is tied to 32'h0. All other behaviour is unchanged.

## Test plan
- Reset low with bytes driven → all outputs 0 and `o_byte_ready`=0. After release, state stays IDLE until `i_start`.
- Start with `i_num_words`=2, bytes 8'h20,8'h08,8'h00,8'h05, 8'h00,8'h85,8'h50,8'h20 at full rate:
  - writes 32'h20080005 @0, then 32'h00855020 @1;
  - `o_mem_we` pulses of 1 cycle, 5 cycles apart;
  - `o_done`=1 with `o_word_count`=2;
  - `o_checksum`=32'h208D5025 when the macro is defined, 0 otherwise.
- Start with `i_num_words`=0 → DONE the next cycle, no write, `o_word_count`=0.
- Random valid gaps and `i_start` pulses during LOAD → same words and addresses as the gap-free run; no restart occurs.
- Reset asserted after 2 bytes of word 1 → no write for the partial word. After release and a new start, writing begins again at address 0.
- ADDR_W=2 with `i_num_words`=5 → count clamps to 4, writes go to addresses 0..3, DONE with `o_word_count`=4.
